// File: rtl/mem_bus_arbiter_if.sv
// Bus bundle between the two cache controllers, the arbiter and main memory.
// The master view belongs to the arbiter. The slave view is the
// environment side, which holds both requesters and the memory model.
interface mem_bus_arbiter_if #(
  parameter int AW = 16,
  parameter int DW = 32
);
  logic          req0_strobe;
  logic          req0_rw;
  logic [AW-1:0] req0_addr;
  logic [DW-1:0] req0_wdata;
  logic          req0_rdy;
  logic          req1_strobe;
  logic          req1_rw;
  logic [AW-1:0] req1_addr;
  logic [DW-1:0] req1_wdata;
  logic          req1_rdy;
  logic [DW-1:0] rdata;
  logic          mem_strobe;
  logic          mem_rw;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  logic          grant;
  logic          busy;

  modport master (
    input  req0_strobe, req0_rw, req0_addr, req0_wdata,
    input  req1_strobe, req1_rw, req1_addr, req1_wdata,
    input  mem_rdata,
    output req0_rdy, req1_rdy, rdata,
    output mem_strobe, mem_rw, mem_addr, mem_wdata,
    output grant, busy
  );

  modport slave (
    output req0_strobe, req0_rw, req0_addr, req0_wdata,
    output req1_strobe, req1_rw, req1_addr, req1_wdata,
    output mem_rdata,
    input  req0_rdy, req1_rdy, rdata,
    input  mem_strobe, mem_rw, mem_addr, mem_wdata,
    input  grant, busy
  );
endinterface

// File: rtl/mem_bus_arbiter.sv
// Round-robin arbiter that shares one main-memory port between the I-side
// controller (requester 0) and the D-side controller (requester 1).
// Each access runs IDLE -> ISSUE -> WAIT -> DONE. The memory latency is
// counted inside this block, because the memory gives no ready signal.
module mem_bus_arbiter #(
  parameter int AW      = 16,
  parameter int DW      = 32,
  parameter int MEM_LAT = 4
) (
  input logic               clk,
  input logic               reset,
  mem_bus_arbiter_if.master bus
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

  // The counter is loaded with MEM_LAT-1 and counts down to 0.
  // WAIT therefore lasts MEM_LAT cycles, and its last cycle is when mem_rdata is valid.
  localparam logic [7:0] CNT_INIT = 8'(MEM_LAT - 1);

  state_t        state_q, state_d;
  logic [7:0]    cnt_q, cnt_d;
  logic          lastGrant_q, lastGrant_d;
  logic          grant_q, grant_d;
  logic          cmdRw_q, cmdRw_d;
  logic [AW-1:0] cmdAddr_q, cmdAddr_d;
  logic [DW-1:0] cmdWdata_q, cmdWdata_d;
  logic [DW-1:0] rdata_q, rdata_d;
  logic          winner;

  // State and datapath registers. Reset abandons any access in flight.
  // lastGrant starts at 1 so that requester 0 wins the first contested arbitration.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      lastGrant_q <= 1'b1;
      grant_q     <= 1'b0;
      cmdRw_q     <= 1'b0;
      cmdAddr_q   <= '0;
      cmdWdata_q  <= '0;
      rdata_q     <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      lastGrant_q <= lastGrant_d;
      grant_q     <= grant_d;
      cmdRw_q     <= cmdRw_d;
      cmdAddr_q   <= cmdAddr_d;
      cmdWdata_q  <= cmdWdata_d;
      rdata_q     <= rdata_d;
    end
  end

  // Next-state logic. Requester inputs are only looked at in IDLE.
  // Once a command is latched, it is unaffected by later input changes.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    lastGrant_d = lastGrant_q;
    grant_d     = grant_q;
    cmdRw_d     = cmdRw_q;
    cmdAddr_d   = cmdAddr_q;
    cmdWdata_d  = cmdWdata_q;
    rdata_d     = rdata_q;
    winner      = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (bus.req0_strobe || bus.req1_strobe) begin
          if (bus.req0_strobe && bus.req1_strobe) begin
            winner = ~lastGrant_q;
          end else begin
            winner = bus.req1_strobe;
          end
          grant_d    = winner;
          cmdRw_d    = winner ? bus.req1_rw    : bus.req0_rw;
          cmdAddr_d  = winner ? bus.req1_addr  : bus.req0_addr;
          cmdWdata_d = winner ? bus.req1_wdata : bus.req0_wdata;
          state_d    = ISSUE;
        end
      end
      ISSUE: begin
        cnt_d   = CNT_INIT;
        state_d = WAIT;
      end
      WAIT: begin
        if (cnt_q == 8'd0) begin
          if (cmdRw_q) begin
            rdata_d = bus.mem_rdata;
          end
          state_d = DONE;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      DONE: begin
        lastGrant_d = grant_q;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.mem_strobe = (state_q == ISSUE);
  assign bus.mem_rw     = cmdRw_q;
  assign bus.mem_addr   = cmdAddr_q;
  assign bus.mem_wdata  = cmdWdata_q;
  assign bus.req0_rdy   = (state_q == DONE) && !grant_q;
  assign bus.req1_rdy   = (state_q == DONE) && grant_q;
  assign bus.rdata      = rdata_q;
  assign bus.grant      = grant_q;
  assign bus.busy       = (state_q != IDLE);

endmodule
